writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have `CLK`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `RST`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have `MemWb_AluOut`, input, 32 bits: ALU result from the MEM/WB register.
REQ-004 The block SHALL have `MemWb_ReadData`, input, 32 bits: load data from the MEM/WB register.
REQ-005 The block SHALL have `MemWb_AddrRdRt`, input, 5 bits: destination register index.
REQ-006 The block SHALL have `MemWb_MemtoReg`, input, 1 bit: 1 selects `MemWb_ReadData`, 0 selects `MemWb_AluOut`.
REQ-007 The block SHALL have `MemWb_RegWrite`, input, 1 bit: writeback enable.
REQ-008 The block SHALL have `IfId_AddrRs`, input, 5 bits: first source register index from decode.
REQ-009 The block SHALL have `IfId_AddrRt`, input, 5 bits: second source register index from decode.
REQ-010 The block SHALL have `IdEx_Stall`, input, 1 bit: hold the ID/EX operand registers.
REQ-011 The block SHALL have `IdEx_Flush`, input, 1 bit: clear the ID/EX operand registers (bubble).
REQ-012 The block SHALL have `IdEx_DataRs`, output, 32 bits: registered Rs operand.
REQ-013 The block SHALL have `IdEx_DataRt`, output, 32 bits: registered Rt operand.
REQ-014 The block SHALL have `Wb_Data`, output, 32 bits: combinational writeback value (mux output) for forwarding.
REQ-015 The block SHALL have `Retire_Count`, output, 32 bits: registered count of committed register writes.

Function
REQ-016 `Wb_Data` SHALL equal `MemWb_ReadData` when `MemWb_MemtoReg`=1, else `MemWb_AluOut`, independent of `MemWb_RegWrite`.
REQ-017 The register file SHALL be 32 entries x 32 bits; entry 0 SHALL always read 0 and SHALL ignore writes.
REQ-018 On a rising edge with `RST`=0, `MemWb_RegWrite`=1 and `MemWb_AddrRdRt`!=0, entry[`MemWb_AddrRdRt`] SHALL take `Wb_Data`.
REQ-019 Source read SHALL be a combinational array read with write-through bypass: if `MemWb_RegWrite`=1, the address is nonzero, and the address equals `MemWb_AddrRdRt`, the read value SHALL be `Wb_Data`.
REQ-020 With no bypass match, the read value SHALL be the stored entry.
REQ-021 Rs and Rt SHALL be bypassed independently; both SHALL bypass when both match.
REQ-022 Operand latency SHALL be 1 cycle: addresses presented before edge N SHALL appear on `IdEx_DataRs`/`IdEx_DataRt` after edge N.
REQ-023 ID/EX update priority on each edge SHALL be `RST` > `IdEx_Flush` (load 0) > `IdEx_Stall` (hold) > load bypassed read values.
REQ-024 A stall SHALL NOT block a register-file write; a write during a stall SHALL NOT alter held ID/EX values.
REQ-025 `Retire_Count` SHALL increment by 1 on each edge meeting the write condition in REQ-018.
REQ-026 `Retire_Count` SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 Writes to register 0 SHALL NOT increment `Retire_Count`.

Reset
REQ-028 On an edge with `RST`=1, all 32 register entries, `IdEx_DataRs`, `IdEx_DataRt` and `Retire_Count` SHALL become 0.
REQ-029 A writeback presented in a reset cycle SHALL be discarded and SHALL NOT be counted.
REQ-030 `Wb_Data` SHALL remain combinational during reset.
REQ-031 Reset asserted mid-stall SHALL clear the held operands.
REQ-032 Operation SHALL resume normally on the first edge after `RST` deasserts.

Verification
REQ-033 Write/read: write r5=0x0000_00AA (`MemtoReg`=0), then `IfId_AddrRs`=5 -> `IdEx_DataRs`=0x0000_00AA one edge later; `Retire_Count`=1.
REQ-034 Same-cycle bypass: `MemWb_RegWrite`=1, `AddrRdRt`=7, `MemtoReg`=1, `ReadData`=0xDEAD_BEEF, `IfId_AddrRs`=`IfId_AddrRt`=7 -> both outputs 0xDEAD_BEEF after that edge.
REQ-035 Register 0: write 0x1234_5678 to r0 -> reading r0 gives 0; `Retire_Count` unchanged; no bypass.
REQ-036 Stall/flush: load operands 0x11/0x22, assert `IdEx_Stall` for 3 cycles with changing addresses -> outputs hold 0x11/0x22; assert `IdEx_Flush` and `IdEx_Stall` together -> outputs 0.
REQ-037 Reset: populate r1-r31, assert `RST` 1 cycle together with a write to r3 -> every register reads 0, `Retire_Count`=0.
REQ-038 Wrap: force `Retire_Count` to 0xFFFF_FFFF via 2^32-1 writes (or a bench backdoor), then one more write -> 0.

Source files
------------

// File: rtl/writeback_regfile.sv
// Writeback stage merged with a 32x32 register file and the ID/EX operand registers.
// Reads bypass the same-cycle writeback; a counter tracks committed register writes.
module writeback_regfile (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] MemWb_AluOut,
  input  logic [31:0] MemWb_ReadData,
  input  logic [4:0]  MemWb_AddrRdRt,
  input  logic        MemWb_MemtoReg,
  input  logic        MemWb_RegWrite,
  input  logic [4:0]  IfId_AddrRs,
  input  logic [4:0]  IfId_AddrRt,
  input  logic        IdEx_Stall,
  input  logic        IdEx_Flush,
  output logic [31:0] IdEx_DataRs,
  output logic [31:0] IdEx_DataRt,
  output logic [31:0] Wb_Data,
  output logic [31:0] Retire_Count
);

  logic [31:0] regs [32];
  logic [31:0] rs_read;
  logic [31:0] rt_read;
  logic [31:0] retire_count;
  logic        commit;

  assign Wb_Data      = MemWb_MemtoReg ? MemWb_ReadData : MemWb_AluOut;
  assign commit       = MemWb_RegWrite && (MemWb_AddrRdRt != 5'd0);
  assign Retire_Count = retire_count;

  // Register 0 is hardwired to zero and is never a bypass target.
  always_comb begin
    rs_read = '0;
    if (IfId_AddrRs != 5'd0) begin
      if (commit && (IfId_AddrRs == MemWb_AddrRdRt)) rs_read = Wb_Data;
      else                                          rs_read = regs[IfId_AddrRs];
    end
  end

  always_comb begin
    rt_read = '0;
    if (IfId_AddrRt != 5'd0) begin
      if (commit && (IfId_AddrRt == MemWb_AddrRdRt)) rt_read = Wb_Data;
      else                                          rt_read = regs[IfId_AddrRt];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[MemWb_AddrRdRt] <= Wb_Data;
    end
  end

  // Flush wins over stall so a bubble can be inserted while decode is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      IdEx_DataRs <= '0;
      IdEx_DataRt <= '0;
    end else if (IdEx_Flush) begin
      IdEx_DataRs <= '0;
      IdEx_DataRt <= '0;
    end else if (!IdEx_Stall) begin
      IdEx_DataRs <= rs_read;
      IdEx_DataRt <= rt_read;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)         retire_count <= '0;
    else if (commit) retire_count <= retire_count + 32'd1;
  end

endmodule
